// File: rtl/convolver_pkg.sv
// Shared types and constants for the streaming 2-D convolution engine.
// Optional feature macro: CONVOLVER_SAT_EN (saturating result instead of wrap).
package convolver_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam acc_t ACC_MAX = 32'sh7FFF_FFFF;
    localparam acc_t ACC_MIN = 32'sh8000_0000;

endpackage

// File: rtl/convolver_line_buffer.sv
// One raster line of delay: the output is the pixel accepted 'depth' enabled
// cycles earlier, i.e. the pixel directly above the current one.
module convolver_line_buffer
    import convolver_pkg::*;
#(
    parameter int depth = 4
) (
    input  logic  clk,
    input  logic  ce,
    input  data_t pixel,
    output data_t delayed
);

    data_t mem [depth];

    // Shift one position per accepted pixel; contents are never cleared.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem[0] <= pixel;
            for (int i = 1; i < depth; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign delayed = mem[depth-1];

endmodule

// File: rtl/convolver.sv
// Streaming k x k convolution over an n x n raster frame at stride s.
// The window seen at the accept edge already contains the incoming pixel,
// so each result is registered one cycle after its bottom-right pixel.
// Optional feature macro: CONVOLVER_SAT_EN (saturate sum to 32-bit range).
module convolver
    import convolver_pkg::*;
#(
    parameter int n = 4,
    parameter int k = 3,
    parameter int s = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [k*k*DATA_W-1:0] weight1,
    input  data_t                 activation,
    output acc_t                  conv_op,
    output logic                  valid_conv,
    output logic                  end_conv
);

    localparam int CW   = (n > 1) ? $clog2(n) : 1;
    localparam int LAST = (k - 1) + ((n - k) / s) * s;

`ifdef CONVOLVER_SAT_EN
    localparam int SUM_W = ACC_W + $clog2(k * k) + 1;
`else
    localparam int SUM_W = ACC_W;
`endif

    typedef logic signed [SUM_W-1:0] sum_t;

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    data_t         row_in   [k];
    data_t         window   [k][k];
    data_t         next_win [k][k];
    data_t         wt;
    acc_t          prod;
    sum_t          total;
    acc_t          result;
    logic          window_ok;
    logic          frame_last;

    // Bottom window row is fed by the live pixel, upper rows by line buffers.
    assign row_in[k-1] = activation;

    for (genvar i = 0; i < k - 1; i++) begin : g_lb
        convolver_line_buffer #(.depth(n)) u_lb (
            .clk     (clk),
            .ce      (ce),
            .pixel   (row_in[k-1-i]),
            .delayed (row_in[k-2-i])
        );
    end

    // Window contents after this cycle's shift, including the incoming column.
    always_comb begin
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k - 1; c++) begin
                next_win[r][c] = window[r][c+1];
            end
            next_win[r][k-1] = row_in[r];
        end
    end

    // Window register shifts left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (ce) begin
            window <= next_win;
        end
    end

    // Multiply-accumulate over the window, then wrap or saturate to 32 bits.
    always_comb begin
        total = '0;
        wt    = '0;
        prod  = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                wt    = weight1[DATA_W*(r*k+c) +: DATA_W];
                prod  = acc_t'(next_win[r][c]) * acc_t'(wt);
                total = total + sum_t'(prod);
            end
        end
`ifdef CONVOLVER_SAT_EN
        if (total > sum_t'(ACC_MAX)) begin
            result = ACC_MAX;
        end else if (total < sum_t'(ACC_MIN)) begin
            result = ACC_MIN;
        end else begin
            result = acc_t'(total);
        end
`else
        result = acc_t'(total);
`endif
    end

    // Decide whether the pixel being accepted completes a strided window.
    always_comb begin
        window_ok  = (int'(row) >= k - 1) && (int'(col) >= k - 1) &&
                     (((int'(row) - (k - 1)) % s) == 0) &&
                     (((int'(col) - (k - 1)) % s) == 0);
        frame_last = (int'(row) == LAST) && (int'(col) == LAST);
    end

    // Raster position counters and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            conv_op    <= '0;
            valid_conv <= 1'b0;
            end_conv   <= 1'b0;
        end else begin
            valid_conv <= 1'b0;
            end_conv   <= 1'b0;
            if (ce) begin
                if (col == CW'(n - 1)) begin
                    col <= '0;
                    row <= (row == CW'(n - 1)) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (window_ok) begin
                    conv_op    <= result;
                    valid_conv <= 1'b1;
                    end_conv   <= frame_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_convolver.sv
// Scoreboard bench for convolver: three instances cover n=4/k=3/s=1,
// n=5/k=3/s=2 and n=k=3 overflow; drivers queue expected results, and
// per-instance monitors pop and compare whenever valid_conv is seen.
module tb_convolver;
    import convolver_pkg::*;

    typedef struct packed {
        logic [31:0] val;
        logic        fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic ce1, ce2, ce3;
    data_t act1, act2, act3;
    logic [143:0] w1, w2, w3;
    acc_t conv1, conv2, conv3;
    logic valid1, valid2, valid3;
    logic end1, end2, end3;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t m1, m2, m3;

    int tests = 0;
    int fails = 0;

`ifdef CONVOLVER_SAT_EN
    localparam logic [31:0] BIG_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] BIG_EXP = 32'h3FF7_0009;
`endif

    // Free-running clock
    always #5 clk = ~clk;

    convolver #(.n(4), .k(3), .s(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce1), .weight1(w1), .activation(act1),
        .conv_op(conv1), .valid_conv(valid1), .end_conv(end1));

    convolver #(.n(5), .k(3), .s(2)) dut2 (
        .clk(clk), .rst(rst), .ce(ce2), .weight1(w2), .activation(act2),
        .conv_op(conv2), .valid_conv(valid2), .end_conv(end2));

    convolver #(.n(3), .k(3), .s(1)) dut3 (
        .clk(clk), .rst(rst), .ce(ce3), .weight1(w3), .activation(act3),
        .conv_op(conv3), .valid_conv(valid3), .end_conv(end3));

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: output seen with nothing expected", name);
    endtask

    task automatic applyStimulus(input int which, input logic [15:0] act, input bit push,
                                 input logic [31:0] val, input bit fin);
        exp_t e;
        e.val = val;
        e.fin = fin;
        @(negedge clk);
        ce1 = 1'b0;
        ce2 = 1'b0;
        ce3 = 1'b0;
        case (which)
            1: begin ce1 = 1'b1; act1 = act; if (push) q1.push_back(e); end
            2: begin ce2 = 1'b1; act2 = act; if (push) q2.push_back(e); end
            default: begin ce3 = 1'b1; act3 = act; if (push) q3.push_back(e); end
        endcase
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            ce1 = 1'b0;
            ce2 = 1'b0;
            ce3 = 1'b0;
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        ce1 = 1'b0;
        ce2 = 1'b0;
        ce3 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_conv", conv1, 32'd0);
        checkOutput("rst_valid", {31'd0, valid1}, 32'd0);
        checkOutput("rst_end", {31'd0, end1}, 32'd0);
        rst = 1'b0;
    endtask

    // One 4x4 frame of pixels base+0..base+15 with optional ce gap after pixel gapAt
    task automatic runFrame1(input int base, input int gapAt, input int gapLen);
        int ev [4] = '{258, 294, 402, 438};
        for (int i = 0; i < 16; i++) begin
            case (i)
                10: applyStimulus(1, 16'(base + i), 1'b1, 32'(ev[0] + 36 * base), 1'b0);
                11: applyStimulus(1, 16'(base + i), 1'b1, 32'(ev[1] + 36 * base), 1'b0);
                14: applyStimulus(1, 16'(base + i), 1'b1, 32'(ev[2] + 36 * base), 1'b0);
                15: applyStimulus(1, 16'(base + i), 1'b1, 32'(ev[3] + 36 * base), 1'b1);
                default: applyStimulus(1, 16'(base + i), 1'b0, 32'd0, 1'b0);
            endcase
            if (i == gapAt) idle(gapLen);
        end
    endtask

    // Monitor for instance 1
    always begin
        @(posedge clk);
        #2;
        if (valid1) begin
            if (q1.size() == 0) unexpected("d1_valid");
            else begin
                m1 = q1.pop_front();
                checkOutput("d1_conv", conv1, m1.val);
                checkOutput("d1_end", {31'd0, end1}, {31'd0, m1.fin});
            end
        end else if (end1) unexpected("d1_end_without_valid");
    end

    // Monitor for instance 2
    always begin
        @(posedge clk);
        #2;
        if (valid2) begin
            if (q2.size() == 0) unexpected("d2_valid");
            else begin
                m2 = q2.pop_front();
                checkOutput("d2_conv", conv2, m2.val);
                checkOutput("d2_end", {31'd0, end2}, {31'd0, m2.fin});
            end
        end else if (end2) unexpected("d2_end_without_valid");
    end

    // Monitor for instance 3
    always begin
        @(posedge clk);
        #2;
        if (valid3) begin
            if (q3.size() == 0) unexpected("d3_valid");
            else begin
                m3 = q3.pop_front();
                checkOutput("d3_conv", conv3, m3.val);
                checkOutput("d3_end", {31'd0, end3}, {31'd0, m3.fin});
            end
        end else if (end3) unexpected("d3_end_without_valid");
    end

    // Directed stimulus sequence
    initial begin
        rst  = 1'b1;
        ce1  = 1'b0;
        ce2  = 1'b0;
        ce3  = 1'b0;
        act1 = '0;
        act2 = '0;
        act3 = '0;
        for (int j = 0; j < 9; j++) begin
            w1[16*j +: 16] = 16'(j);
            w2[16*j +: 16] = 16'd1;
            w3[16*j +: 16] = 16'h7FFF;
        end
        repeat (2) @(negedge clk);
        checkOutput("init_conv", conv1, 32'd0);
        checkOutput("init_valid", {31'd0, valid1}, 32'd0);
        checkOutput("init_end", {31'd0, end1}, 32'd0);
        rst = 1'b0;

        runFrame1(0, -1, 0);
        idle(2);
        checkOutput("d1_hold", conv1, 32'd438);

        for (int i = 16; i < 20; i++) applyStimulus(1, 16'(i), 1'b0, 32'd0, 1'b0);
        idle(1);
        pulseReset();

        runFrame1(0, 5, 3);
        idle(2);

        for (int i = 0; i < 7; i++) applyStimulus(1, 16'(i), 1'b0, 32'd0, 1'b0);
        pulseReset();
        runFrame1(100, -1, 0);
        idle(2);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(2, 16'd1, (i == 12 || i == 14 || i == 22 || i == 24), 32'd9, (i == 24));
        end
        idle(2);

        for (int i = 0; i < 9; i++) applyStimulus(3, 16'h7FFF, (i == 8), BIG_EXP, (i == 8));
        for (int i = 0; i < 9; i++) applyStimulus(3, 16'hFFFF, (i == 8), 32'hFFFB_8009, (i == 8));
        idle(3);

        checkOutput("d1_drain", 32'(q1.size()), 32'd0);
        checkOutput("d2_drain", 32'(q2.size()), 32'd0);
        checkOutput("d3_drain", 32'(q3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
